// File: rtl/exu_mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : exu_mul_ctrl
// Purpose  : Issue/writeback controller in front of the Booth multiplier,
//            with zero-operand and last-result reuse fast paths.
// Revision : 1.0 - initial release
// ============================================================================
module exu_mul_ctrl #(
    parameter int XLEN           = 32,
    parameter int RAW            = 5,
    parameter bit ZERO_BYPASS_EN = 1'b1,
    parameter bit CACHE_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [RAW-1:0]  req_rd_i,
    output logic            mul_start_o,
    output logic [3:0]      mul_op_o,
    output logic [XLEN-1:0] mul_multiplicand_o,
    output logic [XLEN-1:0] mul_multiplier_o,
    output logic [RAW-1:0]  mul_reg_waddr_o,
    input  logic [XLEN-1:0] mul_result_i,
    input  logic            mul_ready_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [RAW-1:0]  wb_rd_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [3:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [RAW-1:0]  r_rd;
    logic [XLEN-1:0] r_result;

    logic            r_cache_valid;
    logic [3:0]      r_cache_op;
    logic [XLEN-1:0] r_cache_rs1;
    logic [XLEN-1:0] r_cache_rs2;
    logic [XLEN-1:0] r_cache_result;

    logic [3:0]      w_op_dec;
    logic            w_accept;
    logic            w_zero_hit;
    logic            w_cache_hit;
    logic            w_fast_hit;
    logic [XLEN-1:0] w_fast_result;
    logic            w_mul_done;
    logic            w_unused_funct3;

    // Issue never sends funct3[2]=1 to this unit.
    assign w_unused_funct3 = req_funct3_i[2];
    assign w_op_dec        = 4'b0001 << req_funct3_i[1:0];

    assign w_zero_hit    = ZERO_BYPASS_EN && ((req_rs1_i == '0) || (req_rs2_i == '0));
    assign w_cache_hit   = CACHE_EN && r_cache_valid && (r_cache_op == w_op_dec) &&
                           (r_cache_rs1 == req_rs1_i) && (r_cache_rs2 == req_rs2_i);
    assign w_fast_hit    = w_zero_hit || w_cache_hit;
    assign w_fast_result = w_zero_hit ? '0 : r_cache_result;

    assign w_accept   = req_valid_i && req_ready_o;
    assign w_mul_done = (r_state == S_WAIT) && mul_ready_i && !flush_i;

    always_comb begin
        w_next_state = r_state;
        req_ready_o  = 1'b0;
        mul_start_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    w_next_state = w_fast_hit ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Start drops with the done pulse so the multiplier never re-arms.
                mul_start_o = !mul_ready_i && !flush_i;
                if (flush_i) begin
                    w_next_state = S_IDLE;
                end else if (mul_ready_i) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i || wb_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
            r_result       <= '0;
            r_cache_valid  <= 1'b0;
            r_cache_op     <= '0;
            r_cache_rs1    <= '0;
            r_cache_rs2    <= '0;
            r_cache_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op  <= w_op_dec;
                r_rs1 <= req_rs1_i;
                r_rs2 <= req_rs2_i;
                r_rd  <= req_rd_i;
                if (w_fast_hit) begin
                    r_result <= w_fast_result;
                end
            end
            // Flushed results never reach the cache.
            if (w_mul_done) begin
                r_result <= mul_result_i;
                if (CACHE_EN) begin
                    r_cache_valid  <= 1'b1;
                    r_cache_op     <= r_op;
                    r_cache_rs1    <= r_rs1;
                    r_cache_rs2    <= r_rs2;
                    r_cache_result <= mul_result_i;
                end
            end
        end
    end

    assign mul_op_o           = r_op;
    assign mul_multiplicand_o = r_rs1;
    assign mul_multiplier_o   = r_rs2;
    assign mul_reg_waddr_o    = r_rd;
    assign wb_valid_o         = (r_state == S_RESP);
    assign wb_data_o          = r_result;
    assign wb_rd_o            = r_rd;
    assign busy_o             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exu_mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_exu_mul_ctrl
// Purpose  : Self-checking bench for exu_mul_ctrl with a multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exu_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_rs1_i = '0;
    logic [31:0] req_rs2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        mul_start_o;
    logic [3:0]  mul_op_o;
    logic [31:0] mul_multiplicand_o;
    logic [31:0] mul_multiplier_o;
    logic [4:0]  mul_reg_waddr_o;
    logic [31:0] mul_result_i;
    logic        mul_ready_i;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference cache: last op that completed through the multiplier.
    logic        rc_valid = 1'b0;
    logic [2:0]  rc_f3 = '0;
    logic [31:0] rc_a = '0, rc_b = '0, rc_res = '0;

    always #5 clk = ~clk;

    exu_mul_ctrl #(.XLEN(32), .RAW(5), .ZERO_BYPASS_EN(1'b1), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rd_i(req_rd_i), .mul_start_o(mul_start_o), .mul_op_o(mul_op_o),
        .mul_multiplicand_o(mul_multiplicand_o), .mul_multiplier_o(mul_multiplier_o),
        .mul_reg_waddr_o(mul_reg_waddr_o), .mul_result_i(mul_result_i),
        .mul_ready_i(mul_ready_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3[1:0])
            2'd0:    begin up = ua * ub;          return up[31:0];  end
            2'd1:    begin sp = sa * sb;          return sp[63:32]; end
            2'd2:    begin sp = sa * longint'(ub); return sp[63:32]; end
            default: begin up = ua * ub;          return up[63:32]; end
        endcase
    endfunction

    function automatic logic [2:0] onehot_to_f3(input logic [3:0] oh);
        case (oh)
            4'b0001: return 3'd0;
            4'b0010: return 3'd1;
            4'b0100: return 3'd2;
            4'b1000: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Multiplier model: captures on the first start edge, done pulse 18 cycles later,
    // aborts if start drops early.
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    logic        spur_ready = 1'b0;

    assign mul_ready_i  = (m_active && m_cnt == 0) || spur_ready;
    assign mul_result_i = spur_ready ? 32'hDEADBEEF : m_res;

    always @(posedge clk) begin
        if (!m_active) begin
            if (mul_start_o) begin
                m_active <= 1'b1;
                m_cnt    <= 17;
                m_res    <= (onehot_to_f3(mul_op_o) == 3'd7) ? 32'hBADBAD00 :
                            ref_mul(onehot_to_f3(mul_op_o), mul_multiplicand_o, mul_multiplier_o);
            end
        end else if (m_cnt == 0) begin
            m_active <= 1'b0;
        end else if (!mul_start_o) begin
            m_active <= 1'b0;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_rs1_i    = a;
        req_rs2_i    = b;
        req_rd_i     = rd;
        @(posedge clk); #1;
        req_valid_i  = 1'b0;
        req_rs1_i    = $urandom;
        req_rs2_i    = $urandom;
        req_rd_i     = 5'($urandom);
    endtask

    // Returns at the negedge of the first wb_valid cycle (lat=-1 if none within budget).
    task automatic run_to_wb(output int lat, output int starts, output logic [31:0] data, output logic [4:0] rd);
        int cyc = 1;
        lat = -1; starts = 0; data = '0; rd = '0;
        while (lat < 0 && cyc <= 40) begin
            @(negedge clk);
            if (mul_start_o) starts++;
            if (wb_valid_o) begin
                lat = cyc; data = wb_data_o; rd = wb_rd_o;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready_o, mul_start_o, wb_valid_o, busy_o} !== 4'b1000)
            $display("FAIL reset_ctrl: got ready/start/valid/busy=%b want 1000", {req_ready_o, mul_start_o, wb_valid_o, busy_o});
        else n_pass++;
        n_checks++;
        if ({mul_op_o, mul_multiplicand_o, mul_multiplier_o, mul_reg_waddr_o, wb_data_o, wb_rd_o} !== '0)
            $display("FAIL reset_data: got op=%h a=%h b=%h wa=%h d=%h rd=%h want all 0",
                     mul_op_o, mul_multiplicand_o, mul_multiplier_o, mul_reg_waddr_o, wb_data_o, wb_rd_o);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        int lat, starts; logic [31:0] d; logic [4:0] rd;
        accept(3'd0, 32'd7, 32'd6, 5'd5);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 20) $display("FAIL basic_latency: got %0d want 20", lat); else n_pass++;
        n_checks++; if (starts !== 18) $display("FAIL basic_start_cycles: got %0d want 18", starts); else n_pass++;
        n_checks++; if (d !== 32'h2A) $display("FAIL basic_data: got %h want 0000002a", d); else n_pass++;
        n_checks++; if (rd !== 5'd5) $display("FAIL basic_rd: got %0d want 5", rd); else n_pass++;
        n_checks++;
        if ({mul_op_o, mul_multiplicand_o, mul_multiplier_o, mul_reg_waddr_o} !== {4'b0001, 32'd7, 32'd6, 5'd5})
            $display("FAIL basic_mul_regs: got op=%b a=%h b=%h wa=%0d want 0001/7/6/5",
                     mul_op_o, mul_multiplicand_o, mul_multiplier_o, mul_reg_waddr_o);
        else n_pass++;
        n_checks++; if ({req_ready_o, busy_o} !== 2'b01) $display("FAIL basic_resp_flags: got ready/busy=%b want 01", {req_ready_o, busy_o}); else n_pass++;
        rc_valid = 1'b1; rc_f3 = 3'd0; rc_a = 32'd7; rc_b = 32'd6; rc_res = 32'h2A;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if ({wb_valid_o, busy_o, req_ready_o} !== 3'b001) $display("FAIL basic_idle: got valid/busy/ready=%b want 001", {wb_valid_o, busy_o, req_ready_o}); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_fast_path();
        int lat, starts; logic [31:0] d; logic [4:0] rd;
        logic [2:0]  f3 [3] = '{3'd0, 3'd3, 3'd0};
        logic [31:0] av [3] = '{32'h1234, 32'h0, 32'd7};
        logic [31:0] bv [3] = '{32'h0, 32'h55, 32'd6};
        logic [31:0] ev [3] = '{32'h0, 32'h0, 32'h2A};
        for (int i = 0; i < 3; i++) begin
            accept(f3[i], av[i], bv[i], 5'(i + 9));
            run_to_wb(lat, starts, d, rd);
            n_checks++; if (lat !== 1 || starts !== 0) $display("FAIL fast_timing[%0d]: got lat=%0d starts=%0d want 1/0", i, lat, starts); else n_pass++;
            n_checks++; if (d !== ev[i] || rd !== 5'(i + 9)) $display("FAIL fast_data[%0d]: got %h rd %0d want %h rd %0d", i, d, rd, ev[i], i + 9); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_high_ops();
        int lat, starts; logic [31:0] d; logic [4:0] rd;
        logic [2:0]  f3 [3] = '{3'd3, 3'd1, 3'd2};
        logic [31:0] av [3] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] ev [3] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            accept(f3[i], av[i], av[i], 5'(i + 1));
            run_to_wb(lat, starts, d, rd);
            n_checks++; if (lat !== 20) $display("FAIL high_latency[%0d]: got %0d want 20", i, lat); else n_pass++;
            n_checks++; if (d !== ev[i]) $display("FAIL high_data[%0d]: got %h want %h", i, d, ev[i]); else n_pass++;
            rc_valid = 1'b1; rc_f3 = f3[i]; rc_a = av[i]; rc_b = av[i]; rc_res = ev[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_wait();
        int lat, starts, seen; logic [31:0] d; logic [4:0] rd;
        logic [31:0] a = 32'h12345678, b = 32'h9ABCDEF0;
        accept(3'd1, a, b, 5'd12);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk); @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({mul_start_o, wb_valid_o} !== 2'b00) $display("FAIL flush_wait_start: got start/valid=%b want 00", {mul_start_o, wb_valid_o}); else n_pass++;
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_wait_idle: got busy=%b want 0", busy_o); else n_pass++;
        seen = 0;
        repeat (25) begin @(negedge clk); if (wb_valid_o) seen++; end
        n_checks++; if (seen !== 0) $display("FAIL flush_wait_no_wb: got %0d valid cycles want 0", seen); else n_pass++;
        @(posedge clk); #1;
        accept(rc_f3, rc_a, rc_b, 5'd3);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 1 || d !== rc_res) $display("FAIL flush_cache_kept: got lat=%0d data=%h want 1/%h", lat, d, rc_res); else n_pass++;
        @(posedge clk); #1;
        accept(3'd1, a, b, 5'd12);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 20 || d !== ref_mul(3'd1, a, b)) $display("FAIL flush_reissue: got lat=%0d data=%h want 20/%h", lat, d, ref_mul(3'd1, a, b)); else n_pass++;
        rc_valid = 1'b1; rc_f3 = 3'd1; rc_a = a; rc_b = b; rc_res = ref_mul(3'd1, a, b);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat, starts, bad; logic [31:0] d; logic [4:0] rd;
        logic [31:0] a = 32'h00C0FFEE, b = 32'h00000123;
        wb_ready_i = 1'b0;
        accept(3'd0, a, b, 5'd17);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 20 || d !== ref_mul(3'd0, a, b)) $display("FAIL bp_first: got lat=%0d data=%h want 20/%h", lat, d, ref_mul(3'd0, a, b)); else n_pass++;
        rc_valid = 1'b1; rc_f3 = 3'd0; rc_a = a; rc_b = b; rc_res = ref_mul(3'd0, a, b);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 spur_ready = (c == 1);
            @(negedge clk);
            if (wb_valid_o !== 1'b1 || wb_data_o !== rc_res || wb_rd_o !== 5'd17 || req_ready_o !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        @(posedge clk); #1 spur_ready = 1'b0; wb_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if ({wb_valid_o, busy_o, req_ready_o} !== 3'b001) $display("FAIL bp_release: got valid/busy/ready=%b want 001", {wb_valid_o, busy_o, req_ready_o}); else n_pass++;
        @(posedge clk); #1 spur_ready = 1'b1;
        @(posedge clk); #1 spur_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({wb_valid_o, busy_o} !== 2'b00) $display("FAIL idle_ignores_ready: got valid/busy=%b want 00", {wb_valid_o, busy_o}); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_resp();
        int lat, starts; logic [31:0] d; logic [4:0] rd;
        wb_ready_i = 1'b0;
        accept(3'd2, 32'h0, 32'h77, 5'd4);
        run_to_wb(lat, starts, d, rd);
        @(posedge clk); #1 flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({wb_valid_o, req_ready_o} !== 2'b10) $display("FAIL flush_resp_same: got valid/ready=%b want 10", {wb_valid_o, req_ready_o}); else n_pass++;
        @(posedge clk); #1 flush_i = 1'b0; wb_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({wb_valid_o, busy_o} !== 2'b00) $display("FAIL flush_resp_next: got valid/busy=%b want 00", {wb_valid_o, busy_o}); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_on_ready();
        int lat, starts, seen, found; logic [31:0] d; logic [4:0] rd;
        logic [31:0] a = 32'hA5A5A5A5, b = 32'h3C3C3C3C;
        accept(3'd3, a, b, 5'd21);
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            if (mul_ready_i) found = 1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (found !== 1) $display("FAIL flush_rdy_seen: got %0d want 1", found); else n_pass++;
        flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if (mul_start_o !== 1'b0) $display("FAIL flush_rdy_start: got %b want 0", mul_start_o); else n_pass++;
        @(posedge clk); #1 flush_i = 1'b0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (wb_valid_o || busy_o) seen++; end
        n_checks++; if (seen !== 0) $display("FAIL flush_rdy_no_wb: got %0d active cycles want 0", seen); else n_pass++;
        @(posedge clk); #1;
        accept(3'd3, a, b, 5'd21);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 20 || d !== ref_mul(3'd3, a, b)) $display("FAIL flush_rdy_no_cache: got lat=%0d data=%h want 20/%h", lat, d, ref_mul(3'd3, a, b)); else n_pass++;
        rc_valid = 1'b1; rc_f3 = 3'd3; rc_a = a; rc_b = b; rc_res = ref_mul(3'd3, a, b);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_wait();
        int lat, starts; logic [31:0] d; logic [4:0] rd;
        accept(3'd0, 32'h11111111, 32'h22222222, 5'd8);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready_o, mul_start_o, wb_valid_o, busy_o} !== 4'b1000 ||
            {mul_op_o, mul_multiplicand_o, mul_multiplier_o, mul_reg_waddr_o, wb_data_o, wb_rd_o} !== '0)
            $display("FAIL reset_in_wait: got ready/start/valid/busy=%b op=%h a=%h d=%h want 1000 and zeros",
                     {req_ready_o, mul_start_o, wb_valid_o, busy_o}, mul_op_o, mul_multiplicand_o, wb_data_o);
        else n_pass++;
        @(posedge clk); #1;
        accept(rc_f3, rc_a, rc_b, 5'd9);
        run_to_wb(lat, starts, d, rd);
        n_checks++; if (lat !== 20 || d !== rc_res) $display("FAIL reset_cache_cleared: got lat=%0d data=%h want 20/%h", lat, d, rc_res); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, starts, mode; logic [31:0] d, a, b, exp; logic [4:0] rd, rdx; logic [2:0] f3; logic fast;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 3));
            mode = $urandom_range(0, 5);
            a = $urandom; b = $urandom;
            if (mode == 0) a = '0;
            else if (mode == 1) b = '0;
            else if (mode == 2 && rc_valid) begin f3 = rc_f3; a = rc_a; b = rc_b; end
            else if (mode == 3) a = 32'($urandom_range(0, 15));
            rdx  = 5'($urandom);
            fast = (a == 0 || b == 0) || (rc_valid && rc_f3 == f3 && rc_a == a && rc_b == b);
            exp  = ref_mul(f3, a, b);
            accept(f3, a, b, rdx);
            run_to_wb(lat, starts, d, rd);
            n_checks++;
            if (lat !== (fast ? 1 : 20) || starts !== (fast ? 0 : 18))
                $display("FAIL rand_timing[%0d]: got lat=%0d starts=%0d want %0d/%0d", i, lat, starts, fast ? 1 : 20, fast ? 0 : 18);
            else n_pass++;
            n_checks++;
            if (d !== exp || rd !== rdx)
                $display("FAIL rand_data[%0d] f3=%0d a=%h b=%h: got %h rd %0d want %h rd %0d", i, f3, a, b, d, rd, exp, rdx);
            else n_pass++;
            if (!fast) begin rc_valid = 1'b1; rc_f3 = f3; rc_a = a; rc_b = b; rc_res = exp; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_fast_path();
        test_high_ops();
        test_flush_wait();
        test_backpressure();
        test_flush_resp();
        test_flush_on_ready();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
